cmd_script_seq: RTL and testbench
=================================

CMD_SCRIPT_SEQ -- requirements
Module: cmd_script_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 2560000: cycles allowed per wait state before timeout.
REQ-002 SHALL have parameter ACK_BYTE, default 8'hA5: required positive-acknowledge response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: script write strobe.
REQ-006 SHALL have port wr_addr, input, 4 bits: script slot written.
REQ-007 SHALL have port wr_data, input, 16 bits: command word written.
REQ-008 SHALL have port num_cmds, input, 5 bits: script length, 0..16.
REQ-009 SHALL have port start, input, 1 bit: begin script, pulse.
REQ-010 SHALL have port abort, input, 1 bit: abandon running script.
REQ-011 SHALL have port cmd, output, 16 bits: command to the remote-comm transmitter.
REQ-012 SHALL have port send_cmd, output, 1 bit: one-cycle transmit request.
REQ-013 SHALL have port cmd_sent, input, 1 bit: transmitter finished sending.
REQ-014 SHALL have port resp_rdy, input, 1 bit: response byte valid.
REQ-015 SHALL have port resp, input, 8 bits: response byte.
REQ-016 SHALL have port busy, output, 1 bit: script in progress.
REQ-017 SHALL have port done, output, 1 bit: script completed without error.
REQ-018 SHALL have port err, output, 1 bit: script terminated on error.
REQ-019 SHALL have port err_code, output, 3 bits: 0 none, 1 sent timeout, 2 resp timeout, 3 bad resp, 4 abort.
REQ-020 SHALL have port cur_idx, output, 4 bits: index of the current or last command.

Function
REQ-021 SHALL hold a 16x16 script memory; each write stores wr_data at wr_addr; writes SHALL be ignored while busy.
REQ-022 SHALL implement FSM states IDLE, SEND, WAIT_SENT, WAIT_RESP, NEXT, FIN.
REQ-023 IDLE: start SHALL clear done, err and err_code, set cur_idx=0, and go to SEND; start SHALL be ignored in any other state.
REQ-024 num_cmds=0 SHALL give done=1 one cycle after start without asserting send_cmd; values above 16 SHALL be treated as 16.
REQ-025 SEND: cmd SHALL equal mem[cur_idx] and send_cmd SHALL be 1 for exactly one cycle, the cycle after start or NEXT; the FSM then goes to WAIT_SENT.
REQ-026 cmd SHALL hold its value until the next SEND.
REQ-027 WAIT_SENT: cmd_sent high SHALL move to WAIT_RESP; resp_rdy SHALL be ignored in this state.
REQ-028 WAIT_RESP: resp_rdy with resp==ACK_BYTE SHALL move to NEXT; any other resp value SHALL set err_code=3.
REQ-029 The timeout counter SHALL be at least 22 bits and clear on entry to each wait state; reaching TIMEOUT_CYC SHALL set err_code 1 or 2 according to the state.
REQ-030 NEXT: if cur_idx+1 equals the effective length, the FSM SHALL go to FIN with done=1; otherwise it SHALL increment cur_idx and go to SEND.
REQ-031 On error the FSM SHALL go to FIN with err=1 and cur_idx holding the failing index.
REQ-032 abort in any non-IDLE state SHALL go to FIN next cycle with err=1, err_code=4, and no further send_cmd.
REQ-033 If abort and a completing event occur in the same cycle, abort SHALL take priority.
REQ-034 busy SHALL be 1 in SEND, WAIT_SENT, WAIT_RESP and NEXT; FIN SHALL return to IDLE next cycle.
REQ-035 done and err SHALL remain set until the next accepted start or reset.

Reset
REQ-036 rst SHALL asynchronously force IDLE and set cmd=0, send_cmd=0, busy=0, done=0, err=0, err_code=0, cur_idx=0, and timeout counter=0.
REQ-037 Reset SHALL NOT clear the script memory; reset during a script SHALL abandon it silently.

Configuration
REQ-038 With CMD_SEQ_RETRY_EN defined, the first sent timeout, resp timeout or bad resp on a command SHALL reissue that command through SEND once, and a second failure SHALL take the error path.
REQ-039 Without CMD_SEQ_RETRY_EN, the first failure SHALL take the error path; abort SHALL never be retried.

Verification
REQ-040 Load 0000,2000,4002; num_cmds=3; start; each command answered by cmd_sent then resp=A5 -> exactly 3 send_cmd pulses with cmd values in order; done=1, err=0, cur_idx=2.
REQ-041 Same script with resp=5A on the second command, macro off -> err=1, err_code=3, cur_idx=1, 2 send_cmd pulses total.
REQ-042 TIMEOUT_CYC=100 and cmd_sent never asserted -> err_code=1 exactly 100 cycles after entering WAIT_SENT; macro on -> second send_cmd, then err after the second timeout.
REQ-043 num_cmds=0 then start -> done=1 the following cycle and no send_cmd; a start pulse while busy -> no effect.
REQ-044 abort during WAIT_RESP -> err_code=4 next cycle; rst mid-script -> all outputs at reset values and script memory contents intact.

Source files
------------

// File: rtl/cmd_script_seq.sv
// ---------------------------------------------------------------------------
// cmd_script_seq
//
// Plays a short script of 16-bit command words to a remote-comm transmitter.
// Each command is sent with a one-cycle send_cmd strobe. The sequencer then
// waits for the transmitter to report cmd_sent, and afterwards for a response
// byte that must equal ACK_BYTE. Each of the two waits is bounded by
// TIMEOUT_CYC cycles. A script is 0..16 words long, and the words are held in
// a 16x16 memory that is loaded through the wr_* port while the sequencer is
// not busy.
//
// Parameters
//   TIMEOUT_CYC : cycles allowed in each wait state before a timeout
//   ACK_BYTE    : the only response byte accepted as an acknowledge
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en/addr/data : script memory write port (ignored while busy)
//   num_cmds        : script length, values above 16 are clamped to 16
//   start, abort    : begin a script (in IDLE only) / abandon a running one
//   cmd, send_cmd   : command word and one-cycle transmit request
//   cmd_sent        : transmitter has finished sending the command
//   resp_rdy, resp  : response byte strobe and value
//   busy, done, err : status flags; done/err are sticky until the next start
//   err_code        : 0 none, 1 sent timeout, 2 resp timeout, 3 bad resp,
//                     4 abort
//   cur_idx         : index of the current command, or the last one
//
// Build option
//   CMD_SEQ_RETRY_EN : when defined, the first failure on a command re-sends
//                      that command once. A second failure on the same
//                      command ends the script with an error. An abort is
//                      never retried.
// ---------------------------------------------------------------------------
module cmd_script_seq #(
    parameter int unsigned TIMEOUT_CYC = 2560000,
    parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [4:0]  num_cmds,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [3:0]  cur_idx
);

    // The timeout counter is never narrower than 22 bits, so the default
    // TIMEOUT_CYC fits.
    localparam int unsigned TMO_W =
        ($clog2(TIMEOUT_CYC + 1) > 22) ? $clog2(TIMEOUT_CYC + 1) : 22;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_SENT = 3'd2,
        WAIT_RESP = 3'd3,
        NEXT      = 3'd4,
        FIN       = 3'd5
    } state_t;

    logic [15:0]      mem_r [16];
    state_t           state_r;
    logic [TMO_W-1:0] tmo_r;
    logic [4:0]       len_r;
`ifdef CMD_SEQ_RETRY_EN
    logic             retry_used_r;
`endif

    logic [4:0]       len_s;
    logic [4:0]       idx_next_s;
    logic             last_s;
    logic             tmo_hit_s;
    logic             running_s;
    logic             fail_s;
    logic             retry_s;
    logic [2:0]       fail_code_s;

    // Script memory. It has no reset, so a reset does not clear the stored script.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Decode the failure events, the last-command test and the retry decision.
    always_comb begin
        len_s       = (num_cmds > 5'd16) ? 5'd16 : num_cmds;
        idx_next_s  = {1'b0, cur_idx} + 5'd1;
        last_s      = (idx_next_s == len_r);
        tmo_hit_s   = (tmo_r == TMO_LAST);
        running_s   = 1'b0;
        fail_s      = 1'b0;
        fail_code_s = 3'd0;
        case (state_r)
            SEND, NEXT: begin
                running_s = 1'b1;
            end
            WAIT_SENT: begin
                running_s = 1'b1;
                // A cmd_sent that arrives on the final cycle still counts as success.
                if (!cmd_sent && tmo_hit_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = 3'd1;
                end else begin
                    fail_s      = 1'b0;
                    fail_code_s = 3'd0;
                end
            end
            WAIT_RESP: begin
                running_s = 1'b1;
                if (resp_rdy) begin
                    if (resp != ACK_BYTE) begin
                        fail_s      = 1'b1;
                        fail_code_s = 3'd3;
                    end else begin
                        fail_s      = 1'b0;
                        fail_code_s = 3'd0;
                    end
                end else if (tmo_hit_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = 3'd2;
                end else begin
                    fail_s      = 1'b0;
                    fail_code_s = 3'd0;
                end
            end
            default: begin
                running_s = 1'b0;
            end
        endcase
`ifdef CMD_SEQ_RETRY_EN
        retry_s = fail_s & ~retry_used_r;
`else
        retry_s = 1'b0;
`endif
    end

    // Sequencer FSM. It drives all registered outputs and the timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cmd          <= 16'h0000;
            send_cmd     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 3'd0;
            cur_idx      <= 4'd0;
            tmo_r        <= '0;
            len_r        <= 5'd0;
`ifdef CMD_SEQ_RETRY_EN
            retry_used_r <= 1'b0;
`endif
        end else begin
            send_cmd <= 1'b0;
            // Abort outranks every other event. It applies only while a script
            // runs, so it cannot turn a finished script into an error.
            if (running_s && abort) begin
                state_r  <= FIN;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= 3'd4;
            end else if (retry_s) begin
                state_r      <= SEND;
                cmd          <= mem_r[cur_idx];
                send_cmd     <= 1'b1;
`ifdef CMD_SEQ_RETRY_EN
                retry_used_r <= 1'b1;
`endif
            end else if (fail_s) begin
                state_r  <= FIN;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= fail_code_s;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            done     <= 1'b0;
                            err      <= 1'b0;
                            err_code <= 3'd0;
                            cur_idx  <= 4'd0;
                            len_r    <= len_s;
                            tmo_r    <= '0;
                            if (len_s == 5'd0) begin
                                state_r <= FIN;
                                done    <= 1'b1;
                            end else begin
                                state_r      <= SEND;
                                cmd          <= mem_r[4'd0];
                                send_cmd     <= 1'b1;
                                busy         <= 1'b1;
`ifdef CMD_SEQ_RETRY_EN
                                retry_used_r <= 1'b0;
`endif
                            end
                        end
                    end
                    SEND: begin
                        state_r <= WAIT_SENT;
                        tmo_r   <= '0;
                    end
                    WAIT_SENT: begin
                        if (cmd_sent) begin
                            state_r <= WAIT_RESP;
                            tmo_r   <= '0;
                        end else begin
                            tmo_r <= tmo_r + 1'b1;
                        end
                    end
                    WAIT_RESP: begin
                        // A bad byte is handled by fail_s, so only an ACK reaches here.
                        if (resp_rdy) begin
                            state_r <= NEXT;
                        end else begin
                            tmo_r <= tmo_r + 1'b1;
                        end
                    end
                    NEXT: begin
                        if (last_s) begin
                            state_r <= FIN;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r      <= SEND;
                            cur_idx      <= idx_next_s[3:0];
                            cmd          <= mem_r[idx_next_s[3:0]];
                            send_cmd     <= 1'b1;
`ifdef CMD_SEQ_RETRY_EN
                            retry_used_r <= 1'b0;
`endif
                        end
                    end
                    FIN: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_script_seq.sv
// ---------------------------------------------------------------------------
// tb_cmd_script_seq
//
// Directed testbench for cmd_script_seq with TIMEOUT_CYC = 100. Inputs change
// 1 ns after each rising edge, and outputs are sampled at the same point. A
// negedge monitor counts send_cmd pulses. Expectations that depend on
// CMD_SEQ_RETRY_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_cmd_script_seq;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  num_cmds;
    logic        start;
    logic        abort;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;
    logic [3:0]  cur_idx;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pulses = 0;
    int          base;
    logic [15:0] exp_mem [16];

    cmd_script_seq #(
        .TIMEOUT_CYC (100),
        .ACK_BYTE    (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .num_cmds (num_cmds),
        .start    (start),
        .abort    (abort),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .cur_idx  (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count transmit strobes mid-cycle.
    always @(negedge clk) begin
        if (send_cmd === 1'b1) n_pulses++;
    end

    // Watchdog: a hung run is reported and stopped.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        num_cmds = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Serve one command. Wait (bounded) for send_cmd and check cmd. Send a
    // stray response during WAIT_SENT that must be ignored. Then report
    // cmd_sent and return the given response byte. The call returns just
    // after the edge that samples the response.
    task automatic serve(input logic [7:0] rbyte, input logic [15:0] exp_cmd, input string tag);
        int k;
        k = 0;
        while (send_cmd !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        chk({tag, " send_cmd"}, {31'd0, send_cmd}, 32'd1);
        chk({tag, " cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
        tick(1);
        resp = 8'h5A; resp_rdy = 1'b1;
        tick(1);
        resp_rdy = 1'b0;
        tick(1);
        cmd_sent = 1'b1;
        tick(1);
        cmd_sent = 1'b0;
        tick(1);
        resp = rbyte; resp_rdy = 1'b1;
        tick(1);
        resp_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
        num_cmds = 5'd0; start = 1'b0; abort = 1'b0;
        cmd_sent = 1'b0; resp_rdy = 1'b0; resp = 8'h00;
        tick(2);
        chk("rst cmd", {16'd0, cmd}, 32'd0);
        chk("rst send_cmd", {31'd0, send_cmd}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst err_code", {29'd0, err_code}, 32'd0);
        chk("rst cur_idx", {28'd0, cur_idx}, 32'd0);
        rst = 1'b0;
        tick(1);

        exp_mem[0] = 16'h0000; exp_mem[1] = 16'h2000; exp_mem[2] = 16'h4002;
        for (int i = 3; i < 16; i++) exp_mem[i] = 16'h0100 + 16'(i);
        for (int i = 0; i < 16; i++) write_word(4'(i), exp_mem[i]);

        // Three-command script, all acknowledged; start while busy is ignored.
        base = n_pulses;
        pulse_start(5'd3);
        chk("t1 busy", {31'd0, busy}, 32'd1);
        serve(8'hA5, 16'h0000, "t1c0");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        serve(8'hA5, 16'h2000, "t1c1");
        tick(1);
        serve(8'hA5, 16'h4002, "t1c2");
        tick(1);
        chk("t1 done", {31'd0, done}, 32'd1);
        chk("t1 err", {31'd0, err}, 32'd0);
        chk("t1 cur_idx", {28'd0, cur_idx}, 32'd2);
        chk("t1 busy end", {31'd0, busy}, 32'd0);
        tick(1);
        chk("t1 done sticky", {31'd0, done}, 32'd1);
        chk("t1 cmd held", {16'd0, cmd}, 32'h4002);
        chk("t1 pulses", 32'(n_pulses - base), 32'd3);
        tick(2);

        // Bad response on the second command.
        base = n_pulses;
        pulse_start(5'd3);
        chk("t2 done cleared", {31'd0, done}, 32'd0);
        serve(8'hA5, 16'h0000, "t2c0");
        tick(1);
        serve(8'h5A, 16'h2000, "t2c1");
`ifdef CMD_SEQ_RETRY_EN
        serve(8'h5A, 16'h2000, "t2c1r");
`endif
        chk("t2 err", {31'd0, err}, 32'd1);
        chk("t2 err_code", {29'd0, err_code}, 32'd3);
        chk("t2 cur_idx", {28'd0, cur_idx}, 32'd1);
        chk("t2 busy", {31'd0, busy}, 32'd0);
        tick(2);
`ifdef CMD_SEQ_RETRY_EN
        chk("t2 pulses", 32'(n_pulses - base), 32'd3);
`else
        chk("t2 pulses", 32'(n_pulses - base), 32'd2);
`endif

        // cmd_sent never arrives: timeout exactly 100 cycles after WAIT_SENT entry.
        base = n_pulses;
        pulse_start(5'd1);
        chk("t3 err cleared", {31'd0, err}, 32'd0);
        tick(1);
        tick(99);
        chk("t3 no err at 99", {31'd0, err}, 32'd0);
        tick(1);
`ifdef CMD_SEQ_RETRY_EN
        chk("t3 retry send", {31'd0, send_cmd}, 32'd1);
        chk("t3 retry no err", {31'd0, err}, 32'd0);
        tick(1);
        tick(99);
        chk("t3 no err at 99 r", {31'd0, err}, 32'd0);
        tick(1);
`endif
        chk("t3 err", {31'd0, err}, 32'd1);
        chk("t3 err_code", {29'd0, err_code}, 32'd1);
        chk("t3 cur_idx", {28'd0, cur_idx}, 32'd0);
        tick(2);
`ifdef CMD_SEQ_RETRY_EN
        chk("t3 pulses", 32'(n_pulses - base), 32'd2);
`else
        chk("t3 pulses", 32'(n_pulses - base), 32'd1);
`endif

        // Response never arrives: response timeout.
        pulse_start(5'd1);
        tick(1);
        cmd_sent = 1'b1;
        tick(1);
        cmd_sent = 1'b0;
        tick(99);
        chk("t3r no err at 99", {31'd0, err}, 32'd0);
        tick(1);
`ifdef CMD_SEQ_RETRY_EN
        chk("t3r retry send", {31'd0, send_cmd}, 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t3r abort code", {29'd0, err_code}, 32'd4);
`else
        chk("t3r err", {31'd0, err}, 32'd1);
        chk("t3r err_code", {29'd0, err_code}, 32'd2);
`endif
        tick(2);

        // Zero-length script: done the next cycle with no transmit.
        base = n_pulses;
        pulse_start(5'd0);
        chk("t4 done", {31'd0, done}, 32'd1);
        chk("t4 err", {31'd0, err}, 32'd0);
        chk("t4 busy", {31'd0, busy}, 32'd0);
        tick(2);
        chk("t4 pulses", 32'(n_pulses - base), 32'd0);

        // Length above 16 is clamped to 16.
        base = n_pulses;
        pulse_start(5'd20);
        for (int i = 0; i < 16; i++) begin
            serve(8'hA5, exp_mem[i], $sformatf("t4l c%0d", i));
            tick(1);
        end
        chk("t4l done", {31'd0, done}, 32'd1);
        chk("t4l cur_idx", {28'd0, cur_idx}, 32'd15);
        tick(2);
        chk("t4l pulses", 32'(n_pulses - base), 32'd16);

        // Abort in WAIT_RESP, issued in the same cycle as a valid ACK.
        base = n_pulses;
        pulse_start(5'd3);
        tick(1);
        cmd_sent = 1'b1;
        tick(1);
        cmd_sent = 1'b0;
        abort = 1'b1; resp = 8'hA5; resp_rdy = 1'b1;
        tick(1);
        abort = 1'b0; resp_rdy = 1'b0;
        chk("t5 err", {31'd0, err}, 32'd1);
        chk("t5 err_code", {29'd0, err_code}, 32'd4);
        chk("t5 done", {31'd0, done}, 32'd0);
        chk("t5 cur_idx", {28'd0, cur_idx}, 32'd0);
        tick(5);
        chk("t5 pulses", 32'(n_pulses - base), 32'd1);

        // Reset in the middle of a script.
        pulse_start(5'd3);
        serve(8'hA5, 16'h0000, "t6c0");
        tick(2);
        rst = 1'b1;
        #1;
        chk("t6 rst cmd", {16'd0, cmd}, 32'd0);
        chk("t6 rst busy", {31'd0, busy}, 32'd0);
        chk("t6 rst send_cmd", {31'd0, send_cmd}, 32'd0);
        chk("t6 rst cur_idx", {28'd0, cur_idx}, 32'd0);
        chk("t6 rst err_code", {29'd0, err_code}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Memory survives reset; a write while busy is dropped.
        base = n_pulses;
        pulse_start(5'd3);
        serve(8'hA5, 16'h0000, "t7c0");
        write_word(4'd2, 16'hFFFF);
        serve(8'hA5, 16'h2000, "t7c1");
        tick(1);
        serve(8'hA5, 16'h4002, "t7c2");
        tick(1);
        chk("t7 done", {31'd0, done}, 32'd1);
        chk("t7 err", {31'd0, err}, 32'd0);
        tick(2);
        chk("t7 pulses", 32'(n_pulses - base), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
